// File: rtl/cnn_mem_loader.sv
// Streams 16-bit words from io into consecutive CNNmemory addresses from a programmable base.
// Optional running checksum of accepted words when CNN_LOAD_CHECKSUM_EN is defined.
module cnn_mem_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 50704
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
`ifdef CNN_LOAD_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              err
);

    typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              accept;

    // Sum is widened by one bit so a base near the top of the address space cannot wrap.
    function automatic logic range_ok(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
        logic [ADDR_W:0] s;
        s = {1'b0, b} + {1'b0, c};
        return (s <= DEPTH_L);
    endfunction

    assign in_ready    = (state_q == LOAD) && !abort;
    assign accept      = in_valid && in_ready;
    assign busy        = (state_q == LOAD);
    assign done        = (state_q == FIN);
    assign mem_we      = we_q;
    assign mem_address = addr_q;
    assign mem_data_in = data_q;
    assign err         = err_q;
`ifdef CNN_LOAD_CHECKSUM_EN
    assign checksum    = sum_q;
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        err_d   = err_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    base_d  = base_addr;
                    count_d = word_count;
                    idx_d   = '0;
                    if (!range_ok(base_addr, word_count)) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else if (word_count == '0) begin
                        err_d   = 1'b0;
                        state_d = FIN;
                    end else begin
                        err_d   = 1'b0;
                        sum_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    we_d   = 1'b1;
                    addr_d = base_q + idx_q;
                    data_d = in_data;
                    idx_d  = idx_q + ADDR_W'(1);
                    sum_d  = sum_q + in_data;
                    if (idx_q + ADDR_W'(1) == count_q) state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_cnn_mem_loader.sv
// Bench for cnn_mem_loader: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized loads.
module tb_cnn_mem_loader;

    localparam int DEPTH = 50704;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, in_valid;
    logic [15:0] base_addr, word_count, in_data;
    logic        in_ready, mem_we, busy, done, err;
    logic [15:0] mem_address, mem_data_in;
`ifdef CNN_LOAD_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    cnn_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
        .busy(busy), .done(done),
`ifdef CNN_LOAD_CHECKSUM_EN
        .checksum(checksum),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0=idle, 1=loading, 2=finishing
    int m_phase, m_next_addr, m_left, m_err, m_sum;
    int m_we, m_addr, m_data;

    typedef struct { int a; int d; } wr_t;
    wr_t wq[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_next_addr = 0; m_left = 0; m_err = 0; m_sum = 0;
        m_we = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(in_ready), 0);
        chk({tag, "_we"}, int'(mem_we), 0);
        chk({tag, "_addr"}, int'(mem_address), 0);
        chk({tag, "_data"}, int'(mem_data_in), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
`ifdef CNN_LOAD_CHECKSUM_EN
        chk({tag, "_csum"}, int'(checksum), 0);
`endif
    endtask

    // One clock: drive inputs after negedge, compare, advance model, wait for next negedge.
    task automatic step(input bit s, input bit a, input int b, input int c,
                        input bit iv, input int d);
        start = s; abort = a; base_addr = 16'(b); word_count = 16'(c);
        in_valid = iv; in_data = 16'(d);
        #1;
        chk("in_ready", int'(in_ready), int'(m_phase == 1 && !a));
        chk("busy", int'(busy), int'(m_phase == 1));
        chk("done", int'(done), int'(m_phase == 2));
        chk("mem_we", int'(mem_we), m_we);
        if (m_we != 0) begin
            chk("mem_address", int'(mem_address), m_addr);
            chk("mem_data_in", int'(mem_data_in), m_data);
        end
        chk("err", int'(err), m_err);
`ifdef CNN_LOAD_CHECKSUM_EN
        chk("checksum", int'(checksum), m_sum);
`endif
        if (mem_we) wq.push_back('{int'(mem_address), int'(mem_data_in)});
        m_we = 0;
        if (m_phase == 0) begin
            if (s && !a) begin
                if (b + c > DEPTH) begin
                    m_err = 1; m_phase = 2;
                end else if (c == 0) begin
                    m_err = 0; m_phase = 2;
                end else begin
                    m_err = 0; m_phase = 1; m_next_addr = b; m_left = c; m_sum = 0;
                end
            end
        end else if (m_phase == 1) begin
            if (a) m_phase = 0;
            else if (iv) begin
                m_we = 1; m_addr = m_next_addr; m_data = d;
                m_next_addr++; m_left--;
                m_sum = (m_sum + d) % 65536;
                if (m_left == 0) m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    int guard;

    initial begin
        rst_n = 1'b0;
        start = 0; abort = 0; in_valid = 0; base_addr = 0; word_count = 0; in_data = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        idle(2);

        // 1: back-to-back load of four words
        wq.delete();
        step(1, 0, 16'h0010, 4, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 16'hA001 + i);
        idle(3);
        chk("t1_nwr", wq.size(), 4);
        if (wq.size() == 4) begin
            chk("t1_a0", wq[0].a, 16'h0010); chk("t1_d0", wq[0].d, 16'hA001);
            chk("t1_a3", wq[3].a, 16'h0013); chk("t1_d3", wq[3].d, 16'hA004);
        end
`ifdef CNN_LOAD_CHECKSUM_EN
        chk("t1_csum", int'(checksum), 16'h800A);
`endif

        // 2: gappy in_valid
        wq.delete();
        step(1, 0, 0, 3, 0, 0);
        step(0, 0, 0, 0, 1, 16'h1111);
        step(0, 0, 0, 0, 0, 16'hDEAD);
        step(0, 0, 0, 0, 0, 16'hDEAD);
        step(0, 0, 0, 0, 1, 16'h2222);
        step(0, 0, 0, 0, 0, 16'hDEAD);
        step(0, 0, 0, 0, 1, 16'h3333);
        idle(3);
        chk("t2_nwr", wq.size(), 3);
        if (wq.size() == 3) chk("t2_a2", wq[2].a, 2);

        // 3: range violation then legal start
        wq.delete();
        step(1, 0, 50700, 5, 1, 16'h5555);
        step(0, 0, 0, 0, 1, 16'h5555);
        idle(2);
        chk("t3_err", int'(err), 1);
        chk("t3_nwr", wq.size(), 0);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0777);
        idle(2);
        chk("t3_err_clr", int'(err), 0);

        // 4: zero-length load
        wq.delete();
        step(1, 0, 16'h0040, 0, 1, 16'h1234);
        idle(3);
        chk("t4_nwr", wq.size(), 0);

        // 5: abort after third accept, with an ignored start mid-load
        wq.delete();
        step(1, 0, 16'h0100, 8, 0, 0);
        step(0, 0, 0, 0, 1, 16'hB000);
        step(1, 0, 16'h0900, 2, 1, 16'hB001);
        step(0, 0, 0, 0, 1, 16'hB002);
        step(0, 1, 0, 0, 1, 16'hB003);
        idle(3);
        chk("t5_nwr", wq.size(), 3);
        if (wq.size() == 3) chk("t5_a2", wq[2].a, 16'h0102);

        // 6: asynchronous reset mid-load, then a clean load
        step(1, 0, 16'h0300, 6, 0, 0);
        step(0, 0, 0, 0, 1, 16'hC000);
        step(0, 0, 0, 0, 1, 16'hC001);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        step(1, 0, 16'h0020, 2, 0, 0);
        step(0, 0, 0, 0, 1, 16'hD000);
        step(0, 0, 0, 0, 1, 16'hD001);
        idle(2);
        chk("t6_nwr", wq.size(), 2);
        if (wq.size() == 2) chk("t6_a1", wq[1].a, 16'h0021);

        // Randomized loads
        for (int n = 0; n < 60; n++) begin
            int b, c, kind;
            kind = int'($urandom_range(0, 9));
            if (kind < 2) begin
                b = int'($urandom_range(0, DEPTH - 1)); c = 0;
            end else if (kind < 4) begin
                b = int'($urandom_range(DEPTH - 16, DEPTH - 1)); c = int'($urandom_range(1, 20));
            end else begin
                b = int'($urandom_range(0, DEPTH - 40)); c = int'($urandom_range(1, 12));
            end
            step(1, ($urandom_range(0, 11) == 0), b, c, 0, 0);
            guard = 0;
            while (m_phase != 0 && guard < 300) begin
                step(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
                     int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                     ($urandom_range(0, 9) < 7), int'($urandom_range(0, 65535)));
                guard++;
            end
            if (guard >= 300) chk("rand_timeout", guard, 0);
            idle(int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
